// File: rtl/sc_regdeser_pkg.sv
// Shared types and constants for the serial receive register.
// Parity option: SC_REGDESER_PARITY_EN.
package sc_regdeser_pkg;

   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_SHIFT  = 2'd1,
      RX_PARITY = 2'd2
   } rx_state_t;

   localparam logic DIR_MSB_FIRST = 1'b0;
   localparam logic DIR_LSB_FIRST = 1'b1;

   // A word is in progress in any state other than idle
   function automatic logic rx_busy(input rx_state_t s);
      return (s != RX_IDLE);
   endfunction

endpackage

// File: rtl/sc_regdeser_outbuf.sv
// One-entry valid/ready holding register for assembled words.
// A word offered while the entry is full and not draining is dropped.
module sc_regdeser_outbuf
   import sc_regdeser_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_word,
   input  logic         i_perr,
   input  logic         i_ready,
   output logic [W-1:0] o_data,
   output logic         o_valid,
   output logic         o_perr,
   output logic         o_overrun
);

   logic [W-1:0] r_data;
   logic         r_valid;
   logic         r_perr;
   logic         r_overrun;
   logic         w_accept;
   logic         w_room;

   assign w_accept = r_valid & i_ready;
   assign w_room   = ~r_valid | i_ready;

   // Entry load/drain; data only changes on a load
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_perr  <= 1'b0;
      end else if (i_load && w_room) begin
         r_data  <= i_word;
         r_valid <= 1'b1;
         r_perr  <= i_perr;
      end else if (w_accept) begin
         r_valid <= 1'b0;
      end
   end

   // Sticky flag for a word lost to a full entry
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_overrun <= 1'b0;
      end else if (i_load && !w_room) begin
         r_overrun <= 1'b1;
      end
   end

   assign o_data    = r_data;
   assign o_valid   = r_valid;
   assign o_perr    = r_perr;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/sc_reg_deserializer.sv
// Serial-in/parallel-out receive register with one-entry output buffer.
// Optional even-parity bit per word: define SC_REGDESER_PARITY_EN.
module sc_reg_deserializer
   import sc_regdeser_pkg::*;
#(
   parameter int DATAWIDTH_BUS   = 32,
   parameter int DATAWIDTH_COUNT = 6
) (
   input  logic                     SC_RegDESER_CLOCK_50,
   input  logic                     SC_RegDESER_Reset_InHigh,
   input  logic                     SC_RegDESER_SerialData_In,
   input  logic                     SC_RegDESER_SerialValid_InHigh,
   input  logic                     SC_RegDESER_Direction_In,
   input  logic                     SC_RegDESER_Clear_InLow,
   input  logic                     SC_RegDESER_DataReady_InHigh,
   output logic [DATAWIDTH_BUS-1:0] SC_RegDESER_DataBUS_Out,
   output logic                     SC_RegDESER_DataValid_OutHigh,
   output logic                     SC_RegDESER_Busy_OutHigh,
   output logic                     SC_RegDESER_Overrun_OutHigh,
   output logic                     SC_RegDESER_ParityError_OutHigh
);

   localparam int W = DATAWIDTH_BUS;
   localparam int C = DATAWIDTH_COUNT;
   localparam logic [C-1:0] LP_LAST = C'(W);

   rx_state_t    r_state;
   logic [C-1:0] r_count;
   logic [W-1:0] r_shift;
   logic         r_dir;

   logic         w_dir;
   logic [W-1:0] w_shift_next;
   logic [C-1:0] w_count_next;
   logic         w_strobe;
   logic         w_last;
   logic         w_load;
   logic [W-1:0] w_word;
   logic         w_perr;
   logic         w_perr_out;

   // Direction is taken live on the first bit, then held for the word
   assign w_dir = (r_state == RX_IDLE) ?
                  SC_RegDESER_Direction_In : r_dir;

   assign w_shift_next = (w_dir == DIR_LSB_FIRST) ?
      {SC_RegDESER_SerialData_In, r_shift[W-1:1]} :
      {r_shift[W-2:0], SC_RegDESER_SerialData_In};

   assign w_count_next = r_count + 1'b1;
   assign w_last       = (w_count_next == LP_LAST);

   // A clear in the same cycle swallows the strobe
   assign w_strobe = SC_RegDESER_SerialValid_InHigh &
                     SC_RegDESER_Clear_InLow;

`ifdef SC_REGDESER_PARITY_EN
   assign w_load = w_strobe & (r_state == RX_PARITY);
   assign w_word = r_shift;
   assign w_perr = (^r_shift) ^ SC_RegDESER_SerialData_In;
`else
   assign w_load = w_strobe & w_last;
   assign w_word = w_shift_next;
   assign w_perr = 1'b0;
`endif

   // Receive FSM, bit counter and shift register
   always_ff @(posedge SC_RegDESER_CLOCK_50) begin
      if (SC_RegDESER_Reset_InHigh) begin
         r_state <= RX_IDLE;
         r_count <= '0;
         r_shift <= '0;
         r_dir   <= DIR_MSB_FIRST;
      end else if (!SC_RegDESER_Clear_InLow) begin
         r_state <= RX_IDLE;
         r_count <= '0;
         r_shift <= '0;
      end else if (SC_RegDESER_SerialValid_InHigh) begin
         unique case (r_state)
            RX_IDLE: begin
               r_dir   <= SC_RegDESER_Direction_In;
               r_shift <= w_shift_next;
               r_count <= w_count_next;
               r_state <= RX_SHIFT;
            end
            RX_SHIFT: begin
               if (w_last) begin
`ifdef SC_REGDESER_PARITY_EN
                  r_shift <= w_shift_next;
                  r_count <= w_count_next;
                  r_state <= RX_PARITY;
`else
                  r_shift <= '0;
                  r_count <= '0;
                  r_state <= RX_IDLE;
`endif
               end else begin
                  r_shift <= w_shift_next;
                  r_count <= w_count_next;
               end
            end
            default: begin
               r_shift <= '0;
               r_count <= '0;
               r_state <= RX_IDLE;
            end
         endcase
      end
   end

   sc_regdeser_outbuf #(
      .W (W)
   ) u_outbuf (
      .i_clk     (SC_RegDESER_CLOCK_50),
      .i_rst     (SC_RegDESER_Reset_InHigh),
      .i_load    (w_load),
      .i_word    (w_word),
      .i_perr    (w_perr),
      .i_ready   (SC_RegDESER_DataReady_InHigh),
      .o_data    (SC_RegDESER_DataBUS_Out),
      .o_valid   (SC_RegDESER_DataValid_OutHigh),
      .o_perr    (w_perr_out),
      .o_overrun (SC_RegDESER_Overrun_OutHigh)
   );

   assign SC_RegDESER_Busy_OutHigh = rx_busy(r_state);

`ifdef SC_REGDESER_PARITY_EN
   assign SC_RegDESER_ParityError_OutHigh = w_perr_out;
`else
   assign SC_RegDESER_ParityError_OutHigh = 1'b0;
   logic w_unused;
   assign w_unused = w_perr_out;
`endif

endmodule
